// File: rtl/div_pkg.sv
// Shared types and constants for the execute-stage iterative divider.
//   div_cmd_e   : operation encoding as presented on CMD_RD
//   div_state_e : sequencer states
//   DIV_ZERO_QUOTIENT / DIV_OVF_QUOTIENT : fixed results for the RISC-V special cases
package div_pkg;

  localparam int DIV_XLEN = 32;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_cmd_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CALC  = 2'b01,
    FIXUP = 2'b10,
    DONE  = 2'b11
  } div_state_e;

  localparam logic [DIV_XLEN-1:0] DIV_ZERO_QUOTIENT = {DIV_XLEN{1'b1}};
  localparam logic [DIV_XLEN-1:0] DIV_OVF_QUOTIENT  = {1'b1, {(DIV_XLEN-1){1'b0}}};

endpackage

// File: rtl/div_ctrl.sv
// Iterative radix-2 restoring divider sequencer for the execute stage.
// Accepts one DIV/DIVU/REM/REMU request, produces one quotient bit per cycle,
// applies RISC-V divide-by-zero / signed-overflow results and sign fix-up, and
// holds the registered result until the execute stage acknowledges it.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   START_DIV, CMD_RD      request strobe and operation (sampled in IDLE only)
//   OP1_SE, OP2_SE         dividend, divisor (latched with START_DIV)
//   FLUSH_SM               abort to IDLE, highest priority
//   RES_ACK_SE             result consumed (honoured in DONE only)
//   BUSY_DIV, DONE_DIV     handshake status
//   RES_DIV                registered result, zero unless DONE_DIV
//
// state | meaning
// IDLE  | waiting for START_DIV
// CALC  | one restoring-division step per cycle, XLEN steps
// FIXUP | sign correction and quotient/remainder select
// DONE  | result held until RES_ACK_SE
module div_ctrl
  import div_pkg::*;
#(
  parameter int XLEN  = DIV_XLEN,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            START_DIV,
  input  logic [1:0]      CMD_RD,
  input  logic [XLEN-1:0] OP1_SE,
  input  logic [XLEN-1:0] OP2_SE,
  input  logic            FLUSH_SM,
  input  logic            RES_ACK_SE,
  output logic            BUSY_DIV,
  output logic            DONE_DIV,
  output logic [XLEN-1:0] RES_DIV
);

  div_state_e      state_q, state_d;
  div_cmd_e        cmd;
  logic [XLEN-1:0] dvd_q, dvs_q, quo_q, rem_q, res_q;
  logic [CNT_W-1:0] cnt_q;
  logic            sel_rem_q, neg_quo_q, neg_rem_q;

  logic            is_signed, is_rem, op1_neg, op2_neg;
  logic            div_zero, ovf, last_iter;
  logic [XLEN-1:0] op1_mag, op2_mag, quo_fix, rem_fix;
  logic [XLEN:0]   shifted, diff;

  assign cmd       = div_cmd_e'(CMD_RD);
  assign is_signed = (cmd == DIV) || (cmd == REM);
  assign is_rem    = (cmd == REM) || (cmd == REMU);
  assign op1_neg   = is_signed & OP1_SE[XLEN-1];
  assign op2_neg   = is_signed & OP2_SE[XLEN-1];
  // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude.
  assign op1_mag   = op1_neg ? -OP1_SE : OP1_SE;
  assign op2_mag   = op2_neg ? -OP2_SE : OP2_SE;
  assign div_zero  = (OP2_SE == '0);
  assign ovf       = is_signed && (OP1_SE == DIV_OVF_QUOTIENT) && (&OP2_SE);

  // Partial remainder stays below the divisor, so XLEN bits hold it between
  // steps; the shifted value and trial difference need the extra bit.
  assign shifted   = {rem_q, dvd_q[XLEN-1]};
  assign diff      = shifted - {1'b0, dvs_q};
  assign last_iter = (cnt_q == CNT_W'(XLEN - 1));

  assign quo_fix   = neg_quo_q ? -quo_q : quo_q;
  assign rem_fix   = neg_rem_q ? -rem_q : rem_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (FLUSH_SM) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (START_DIV) state_d = (div_zero || ovf) ? DONE : CALC;
        CALC:  if (last_iter) state_d = FIXUP;
        FIXUP: state_d = DONE;
        DONE:  if (RES_ACK_SE) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd_q     <= '0;
      dvs_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      sel_rem_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (FLUSH_SM) begin
      quo_q <= '0;
      rem_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (START_DIV) begin
            sel_rem_q <= is_rem;
            if (div_zero) begin
              res_q <= is_rem ? OP1_SE : DIV_ZERO_QUOTIENT;
            end else if (ovf) begin
              res_q <= is_rem ? '0 : DIV_OVF_QUOTIENT;
            end else begin
              dvd_q     <= op1_mag;
              dvs_q     <= op2_mag;
              quo_q     <= '0;
              rem_q     <= '0;
              cnt_q     <= '0;
              neg_quo_q <= op1_neg ^ op2_neg;
              neg_rem_q <= op1_neg;
            end
          end
        end
        CALC: begin
          rem_q <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
          quo_q <= {quo_q[XLEN-2:0], ~diff[XLEN]};
          dvd_q <= {dvd_q[XLEN-2:0], 1'b0};
          cnt_q <= cnt_q + CNT_W'(1);
        end
        FIXUP: res_q <= sel_rem_q ? rem_fix : quo_fix;
        DONE:  if (RES_ACK_SE) res_q <= '0;
        default: ;
      endcase
    end
  end

  assign BUSY_DIV = (state_q != IDLE);
  assign DONE_DIV = (state_q == DONE);
  assign RES_DIV  = res_q;

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        START_DIV;
  logic [1:0]  CMD_RD;
  logic [31:0] OP1_SE;
  logic [31:0] OP2_SE;
  logic        FLUSH_SM;
  logic        RES_ACK_SE;
  logic        BUSY_DIV;
  logic        DONE_DIV;
  logic [31:0] RES_DIV;

  int n_checks = 0;
  int n_fail   = 0;

  div_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .START_DIV (START_DIV),
    .CMD_RD    (CMD_RD),
    .OP1_SE    (OP1_SE),
    .OP2_SE    (OP2_SE),
    .FLUSH_SM  (FLUSH_SM),
    .RES_ACK_SE(RES_ACK_SE),
    .BUSY_DIV  (BUSY_DIV),
    .DONE_DIV  (DONE_DIV),
    .RES_DIV   (RES_DIV)
  );

  always #5 clk = ~clk;

  // Present one request at a negedge, scramble the inputs right after the
  // sampling edge, then count negedges until DONE_DIV (cyc = -1 on timeout).
  task automatic run_op(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int cyc);
    logic done;
    @(negedge clk);
    CMD_RD = cmd; OP1_SE = a; OP2_SE = b; START_DIV = 1'b1;
    @(posedge clk);
    #1;
    START_DIV = 1'b0;
    OP1_SE = $urandom; OP2_SE = $urandom; CMD_RD = 2'($urandom_range(0, 3));
    cyc = 0; done = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (DONE_DIV) done = 1'b1;
    end
    res = RES_DIV;
    if (!done) cyc = -1;
  endtask

  task automatic do_ack();
    @(negedge clk);
    RES_ACK_SE = 1'b1;
    @(posedge clk);
    #1;
    RES_ACK_SE = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks += 3;
    if (BUSY_DIV !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", BUSY_DIV); end
    if (DONE_DIV !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", DONE_DIV); end
    if (RES_DIV !== 32'h0) begin n_fail++; $display("FAIL reset_res got %h want 0", RES_DIV); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_unsigned();
    logic [31:0] r; int c;
    run_op(2'b01, 32'd100, 32'd7, r, c);
    n_checks += 3;
    if (r !== 32'd14) begin n_fail++; $display("FAIL divu_100_7 got %0d want 14", r); end
    if (c !== 34) begin n_fail++; $display("FAIL divu_latency got %0d want 34", c); end
    if (BUSY_DIV !== 1'b1) begin n_fail++; $display("FAIL divu_busy_in_done got %b want 1", BUSY_DIV); end
    do_ack();
    @(negedge clk);
    n_checks += 3;
    if (DONE_DIV !== 1'b0) begin n_fail++; $display("FAIL ack_done got %b want 0", DONE_DIV); end
    if (BUSY_DIV !== 1'b0) begin n_fail++; $display("FAIL ack_busy got %b want 0", BUSY_DIV); end
    if (RES_DIV !== 32'h0) begin n_fail++; $display("FAIL ack_res got %h want 0", RES_DIV); end
    run_op(2'b11, 32'd100, 32'd7, r, c);
    n_checks += 1;
    if (r !== 32'd2) begin n_fail++; $display("FAIL remu_100_7 got %0d want 2", r); end
    do_ack();
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1, r, c);
    n_checks += 1;
    if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_max_1 got %h want ffffffff", r); end
    do_ack();
  endtask

  task automatic test_signed();
    logic [31:0] r; int c;
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, r, c);
    n_checks += 2;
    if (r !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_m7_2 got %h want fffffffd", r); end
    if (c !== 34) begin n_fail++; $display("FAIL div_latency got %0d want 34", c); end
    do_ack();
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, r, c);
    n_checks += 1;
    if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_m7_2 got %h want ffffffff", r); end
    do_ack();
    run_op(2'b00, 32'd7, 32'hFFFF_FFFE, r, c);
    n_checks += 1;
    if (r !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_7_m2 got %h want fffffffd", r); end
    do_ack();
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, r, c);
    n_checks += 1;
    if (r !== 32'd1) begin n_fail++; $display("FAIL rem_7_m2 got %h want 1", r); end
    do_ack();
    run_op(2'b00, 32'h8000_0000, 32'd2, r, c);
    n_checks += 1;
    if (r !== 32'hC000_0000) begin n_fail++; $display("FAIL div_min_2 got %h want c0000000", r); end
    do_ack();
  endtask

  task automatic test_div_zero();
    logic [31:0] r; int c;
    run_op(2'b01, 32'd5, 32'd0, r, c);
    n_checks += 2;
    if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_by_zero got %h want ffffffff", r); end
    if (c !== 1) begin n_fail++; $display("FAIL divu_zero_latency got %0d want 1", c); end
    do_ack();
    run_op(2'b10, 32'd5, 32'd0, r, c);
    n_checks += 2;
    if (r !== 32'd5) begin n_fail++; $display("FAIL rem_by_zero got %h want 5", r); end
    if (c !== 1) begin n_fail++; $display("FAIL rem_zero_latency got %0d want 1", c); end
    do_ack();
  endtask

  task automatic test_overflow();
    logic [31:0] r; int c;
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, r, c);
    n_checks += 2;
    if (r !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf got %h want 80000000", r); end
    if (c !== 1) begin n_fail++; $display("FAIL div_ovf_latency got %0d want 1", c); end
    do_ack();
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, r, c);
    n_checks += 2;
    if (r !== 32'h0) begin n_fail++; $display("FAIL rem_ovf got %h want 0", r); end
    if (c !== 1) begin n_fail++; $display("FAIL rem_ovf_latency got %0d want 1", c); end
    do_ack();
  endtask

  task automatic test_flush();
    logic [31:0] r; int c;
    @(negedge clk);
    CMD_RD = 2'b01; OP1_SE = 32'd12345; OP2_SE = 32'd3; START_DIV = 1'b1;
    @(posedge clk);
    @(negedge clk);
    START_DIV = 1'b0;
    repeat (9) @(negedge clk);
    n_checks += 1;
    if (BUSY_DIV !== 1'b1) begin n_fail++; $display("FAIL flush_pre_busy got %b want 1", BUSY_DIV); end
    FLUSH_SM = 1'b1;
    @(negedge clk);
    FLUSH_SM = 1'b0;
    n_checks += 2;
    if (BUSY_DIV !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %b want 0", BUSY_DIV); end
    if (DONE_DIV !== 1'b0) begin n_fail++; $display("FAIL flush_done got %b want 0", DONE_DIV); end
    run_op(2'b01, 32'd1000, 32'd10, r, c);
    n_checks += 2;
    if (r !== 32'd100) begin n_fail++; $display("FAIL post_flush_divu got %0d want 100", r); end
    if (c !== 34) begin n_fail++; $display("FAIL post_flush_latency got %0d want 34", c); end
    // Flush while DONE drops the held result.
    @(negedge clk);
    FLUSH_SM = 1'b1;
    @(negedge clk);
    FLUSH_SM = 1'b0;
    n_checks += 2;
    if (DONE_DIV !== 1'b0) begin n_fail++; $display("FAIL flush_in_done got %b want 0", DONE_DIV); end
    if (RES_DIV !== 32'h0) begin n_fail++; $display("FAIL flush_res got %h want 0", RES_DIV); end
  endtask

  task automatic test_hold();
    logic [31:0] r; int c;
    run_op(2'b01, 32'd1000, 32'd10, r, c);
    for (int i = 0; i < 5; i++) begin
      CMD_RD = 2'b01; OP1_SE = 32'd9; OP2_SE = 32'd0; START_DIV = (i % 2 == 0);
      @(negedge clk);
      n_checks += 2;
      if (DONE_DIV !== 1'b1) begin n_fail++; $display("FAIL hold_done[%0d] got %b want 1", i, DONE_DIV); end
      if (RES_DIV !== 32'd100) begin n_fail++; $display("FAIL hold_res[%0d] got %0d want 100", i, RES_DIV); end
    end
    // Ack coinciding with a new request: ack wins, request is ignored.
    START_DIV = 1'b1; RES_ACK_SE = 1'b1;
    @(negedge clk);
    START_DIV = 1'b0; RES_ACK_SE = 1'b0;
    n_checks += 1;
    if (BUSY_DIV !== 1'b0) begin n_fail++; $display("FAIL ack_start_busy got %b want 0", BUSY_DIV); end
    @(negedge clk);
    n_checks += 2;
    if (BUSY_DIV !== 1'b0) begin n_fail++; $display("FAIL ack_start_ignored got %b want 0", BUSY_DIV); end
    if (DONE_DIV !== 1'b0) begin n_fail++; $display("FAIL ack_start_done got %b want 0", DONE_DIV); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; int c;
    @(negedge clk);
    CMD_RD = 2'b01; OP1_SE = 32'd77; OP2_SE = 32'd5; START_DIV = 1'b1;
    @(posedge clk);
    @(negedge clk);
    START_DIV = 1'b0;
    // Ack while calculating must not abort the operation.
    RES_ACK_SE = 1'b1;
    @(negedge clk);
    RES_ACK_SE = 1'b0;
    repeat (3) @(negedge clk);
    n_checks += 1;
    if (BUSY_DIV !== 1'b1) begin n_fail++; $display("FAIL ack_in_calc_busy got %b want 1", BUSY_DIV); end
    #2;
    reset = 1'b1;
    #1;
    n_checks += 3;
    if (BUSY_DIV !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b want 0", BUSY_DIV); end
    if (DONE_DIV !== 1'b0) begin n_fail++; $display("FAIL midreset_done got %b want 0", DONE_DIV); end
    if (RES_DIV !== 32'h0) begin n_fail++; $display("FAIL midreset_res got %h want 0", RES_DIV); end
    @(negedge clk);
    reset = 1'b0;
    // Reset while a result is held clears RES_DIV immediately.
    run_op(2'b11, 32'd77, 32'd5, r, c);
    n_checks += 1;
    if (r !== 32'd2) begin n_fail++; $display("FAIL remu_77_5 got %0d want 2", r); end
    #2;
    reset = 1'b1;
    #1;
    n_checks += 2;
    if (RES_DIV !== 32'h0) begin n_fail++; $display("FAIL done_reset_res got %h want 0", RES_DIV); end
    if (DONE_DIV !== 1'b0) begin n_fail++; $display("FAIL done_reset_done got %b want 0", DONE_DIV); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; START_DIV = 1'b0; CMD_RD = 2'b00; OP1_SE = '0; OP2_SE = '0;
    FLUSH_SM = 1'b0; RES_ACK_SE = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_flush();
    test_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
